vga_timing_monitor: RTL

//   Sink-side checker for the VGA interface driven by the display controller.

---
 rtl/vga_timing_monitor.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_monitor.sv
// Sink-side VGA timing checker: recovers active x/y, measures line/frame geometry
// against the expected mode, tracks lock, raises sticky errors and captures a probe pixel.
module vga_timing_monitor #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_TOTAL  = 800,
  parameter int   V_ACTIVE = 480,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank_n,
  input  logic [23:0] rgb,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  input  logic        clr_err,
  output logic [9:0]  x_out,
  output logic [9:0]  y_out,
  output logic [23:0] probe_rgb,
  output logic        probe_valid,
  output logic        locked,
  output logic [15:0] frame_count,
  output logic        err_h,
  output logic        err_v
);

  typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

  localparam logic [10:0] H_ACT_C = 11'(H_ACTIVE);
  localparam logic [10:0] H_TOT_C = 11'(H_TOTAL);
  localparam logic [10:0] V_ACT_C = 11'(V_ACTIVE);
  localparam logic [10:0] CNT_MAX = 11'h7FF;

  state_t      state_q, state_d;
  logic        hs_q, hs_d, vs_q, vs_d, bl_q, bl_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [10:0] act_cnt_q, act_cnt_d, per_cnt_q, per_cnt_d;
  logic        armed_q, armed_d, frame_err_q, frame_err_d;
  logic        locked_q, locked_d, err_h_q, err_h_d, err_v_q, err_v_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [23:0] probe_rgb_q, probe_rgb_d;
  logic        probe_valid_q, probe_valid_d;

  logic        hs_on, vs_on, bl_on;
  logic        hs_edge, vs_edge, bl_rise, bl_fall, act;
  logic [9:0]  pix_x;
  logic [10:0] lines;
  logic        h_mm, v_mm;

  assign hs_on   = (hsync == SYNC_POL);
  assign vs_on   = (vsync == SYNC_POL);
  assign bl_on   = blank_n;
  assign hs_edge = pix_ce & hs_on & ~hs_q;
  assign vs_edge = pix_ce & vs_on & ~vs_q;
  assign bl_rise = pix_ce & bl_on & ~bl_q;
  assign bl_fall = pix_ce & ~bl_on & bl_q;
  assign act     = pix_ce & bl_on;

  // Column of the pixel being sampled right now (x_q still holds the previous one).
  assign pix_x = bl_rise ? 10'd0 : x_q + 10'd1;
  // A line ending on the vsync strobe still belongs to the closing frame.
  assign lines = {1'b0, y_q} + {10'd0, bl_fall};

  assign h_mm = (bl_fall && act_cnt_q != H_ACT_C) ||
                (hs_edge && armed_q && per_cnt_q != H_TOT_C);
  assign v_mm = vs_edge && lines != V_ACT_C;

  always_comb begin
    hs_d = hs_q;
    vs_d = vs_q;
    bl_d = bl_q;
    if (pix_ce) begin
      hs_d = hs_on;
      vs_d = vs_on;
      bl_d = bl_on;
    end

    x_d = x_q;
    if (bl_rise)  x_d = 10'd0;
    else if (act) x_d = x_q + 10'd1;

    y_d = y_q;
    if (vs_edge)      y_d = 10'd0;
    else if (bl_fall) y_d = y_q + 10'd1;

    act_cnt_d = act_cnt_q;
    if (bl_rise)                         act_cnt_d = 11'd1;
    else if (act && act_cnt_q != CNT_MAX) act_cnt_d = act_cnt_q + 11'd1;

    per_cnt_d = per_cnt_q;
    if (hs_edge)                            per_cnt_d = 11'd1;
    else if (pix_ce && per_cnt_q != CNT_MAX) per_cnt_d = per_cnt_q + 11'd1;

    // The period measured at the first hsync after leaving HUNT is not trusted.
    armed_d = armed_q;
    if (state_q == HUNT) armed_d = 1'b0;
    else if (hs_edge)    armed_d = 1'b1;

    probe_valid_d = act && (pix_x == probe_x) && (y_q == probe_y);
    probe_rgb_d   = probe_valid_d ? rgb : probe_rgb_q;

    state_d       = state_q;
    frame_err_d   = frame_err_q;
    frame_count_d = frame_count_q;
    err_h_d       = clr_err ? 1'b0 : err_h_q;
    err_v_d       = clr_err ? 1'b0 : err_v_q;

    case (state_q)
      HUNT: begin
        if (vs_edge) begin
          state_d     = ACQ;
          frame_err_d = 1'b0;
        end
      end
      ACQ: begin
        // vsync verdict uses the closing frame; a coincident hsync fault opens the new one.
        if (vs_edge) begin
          state_d     = (!frame_err_q && !v_mm && !h_mm) ? LOCKED : ACQ;
          frame_err_d = h_mm;
        end else begin
          frame_err_d = frame_err_q | h_mm;
        end
      end
      LOCKED: begin
        if (h_mm || v_mm) begin
          state_d = HUNT;
          if (h_mm) err_h_d = 1'b1;
          if (v_mm) err_v_d = 1'b1;
        end else if (vs_edge) begin
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      default: state_d = HUNT;
    endcase

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      bl_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      act_cnt_q     <= '0;
      per_cnt_q     <= '0;
      armed_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      locked_q      <= 1'b0;
      err_h_q       <= 1'b0;
      err_v_q       <= 1'b0;
      frame_count_q <= '0;
      probe_rgb_q   <= '0;
      probe_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      bl_q          <= bl_d;
      x_q           <= x_d;
      y_q           <= y_d;
      act_cnt_q     <= act_cnt_d;
      per_cnt_q     <= per_cnt_d;
      armed_q       <= armed_d;
      frame_err_q   <= frame_err_d;
      locked_q      <= locked_d;
      err_h_q       <= err_h_d;
      err_v_q       <= err_v_d;
      frame_count_q <= frame_count_d;
      probe_rgb_q   <= probe_rgb_d;
      probe_valid_q <= probe_valid_d;
    end
  end

  assign x_out       = x_q;
  assign y_out       = y_q;
  assign probe_rgb   = probe_rgb_q;
  assign probe_valid = probe_valid_q;
  assign locked      = locked_q;
  assign frame_count = frame_count_q;
  assign err_h       = err_h_q;
  assign err_v       = err_v_q;

endmodule
